// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - four-digit common-anode seven-segment scan driver
// Double-buffered value, per-switch blanking dead time, optional leading-zero blanking.
module seven_seg_scan_driver #(
  parameter int unsigned DEAD_CYCLES = 1024
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [1:0]  LED_activating_counter,
  input  logic [15:0] display_value,
  input  logic [3:0]  dp_mask,
  input  logic        value_valid,
  input  logic        blank_lz,
  output logic        value_ack,
  output logic        frame_done,
  output logic [3:0]  Anode_Activate,
  output logic [6:0]  LED_out,
  output logic        dp_out
);

  localparam logic [15:0] DEAD_LOAD = 16'(DEAD_CYCLES);

  logic [15:0] pend_val_q, pend_val_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic        pend_flag_q, pend_flag_d;
  logic [15:0] shad_val_q, shad_val_d;
  logic [3:0]  shad_dp_q, shad_dp_d;
  logic [1:0]  sel_prev_q;
  logic [15:0] dead_cnt_q, dead_cnt_d;
  logic [3:0]  anode_q, anode_d;
  logic [6:0]  led_q, led_d;
  logic        dp_q, dp_d;
  logic        ack_q;
  logic        frame_q;

  logic        boundary;
  logic [3:0]  nibble;
  logic        dp_bit;
  logic [3:0]  anode_sel;
  logic        lz_hit;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'b0000001;
      4'h1: seg_decode = 7'b1001111;
      4'h2: seg_decode = 7'b0010010;
      4'h3: seg_decode = 7'b0000110;
      4'h4: seg_decode = 7'b1001100;
      4'h5: seg_decode = 7'b0100100;
      4'h6: seg_decode = 7'b0100000;
      4'h7: seg_decode = 7'b0001111;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0000100;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b1100000;
      4'hC: seg_decode = 7'b0110001;
      4'hD: seg_decode = 7'b1000010;
      4'hE: seg_decode = 7'b0110000;
      default: seg_decode = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    boundary    = (sel_prev_q == 2'd3) && (LED_activating_counter == 2'd0);
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    shad_val_d  = shad_val_q;
    shad_dp_d   = shad_dp_q;

    // Shadow takes the old pending before a same-cycle write overwrites it.
    if (boundary && pend_flag_q) begin
      shad_val_d  = pend_val_q;
      shad_dp_d   = pend_dp_q;
      pend_flag_d = 1'b0;
    end
    if (value_valid) begin
      pend_val_d  = display_value;
      pend_dp_d   = dp_mask;
      pend_flag_d = 1'b1;
    end

    if (LED_activating_counter != sel_prev_q) begin
      dead_cnt_d = DEAD_LOAD;
    end else if (dead_cnt_q != 16'd0) begin
      dead_cnt_d = dead_cnt_q - 16'd1;
    end else begin
      dead_cnt_d = 16'd0;
    end

    nibble    = shad_val_q[3:0];
    dp_bit    = shad_dp_q[0];
    anode_sel = 4'b1110;
    lz_hit    = 1'b0;
    case (LED_activating_counter)
      2'd0: begin
        nibble = shad_val_q[15:12]; dp_bit = shad_dp_q[3]; anode_sel = 4'b0111;
        lz_hit = (shad_val_q[15:12] == 4'h0);
      end
      2'd1: begin
        nibble = shad_val_q[11:8]; dp_bit = shad_dp_q[2]; anode_sel = 4'b1011;
        lz_hit = (shad_val_q[15:8] == 8'h00);
      end
      2'd2: begin
        nibble = shad_val_q[7:4]; dp_bit = shad_dp_q[1]; anode_sel = 4'b1101;
        lz_hit = (shad_val_q[15:4] == 12'h000);
      end
      default: begin
        nibble = shad_val_q[3:0]; dp_bit = shad_dp_q[0]; anode_sel = 4'b1110;
        lz_hit = 1'b0;
      end
    endcase

    anode_d = anode_sel;
    led_d   = seg_decode(nibble);
    dp_d    = ~dp_bit;
    // Deciding on the next count keeps the dark window exactly DEAD_CYCLES long.
    if ((dead_cnt_d != 16'd0) || (blank_lz && lz_hit)) begin
      anode_d = 4'b1111;
      led_d   = 7'b1111111;
      dp_d    = 1'b1;
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      pend_val_q  <= 16'd0;
      pend_dp_q   <= 4'd0;
      pend_flag_q <= 1'b0;
      shad_val_q  <= 16'd0;
      shad_dp_q   <= 4'd0;
      sel_prev_q  <= 2'd0;
      dead_cnt_q  <= 16'd0;
      anode_q     <= 4'b1111;
      led_q       <= 7'b1111111;
      dp_q        <= 1'b1;
      ack_q       <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      shad_val_q  <= shad_val_d;
      shad_dp_q   <= shad_dp_d;
      sel_prev_q  <= LED_activating_counter;
      dead_cnt_q  <= dead_cnt_d;
      anode_q     <= anode_d;
      led_q       <= led_d;
      dp_q        <= dp_d;
      ack_q       <= value_valid;
      frame_q     <= boundary;
    end
  end

  assign value_ack      = ack_q;
  assign frame_done     = frame_q;
  assign Anode_Activate = anode_q;
  assign LED_out        = led_q;
  assign dp_out         = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - scoreboard bench for seven_seg_scan_driver
module tb_seven_seg_scan_driver;

  localparam int DEAD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [15:0] display_value;
  logic [3:0]  dp_mask;
  logic        value_valid;
  logic        blank_lz;
  logic        value_ack;
  logic        frame_done;
  logic [3:0]  Anode_Activate;
  logic [6:0]  LED_out;
  logic        dp_out;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_img_q[$];
  logic        exp_fr_q[$];
  logic        exp_ack_q[$];

  logic [15:0] m_shadow, m_pend;
  logic [3:0]  m_sdp, m_pdp;
  logic        m_flag;
  logic [1:0]  cur_sel;
  logic [6:0]  seg_tab[16];

  typedef struct {
    logic [1:0]  s;
    logic        wr;
    logic [15:0] v;
    logic [3:0]  d;
  } step_t;

  seven_seg_scan_driver #(.DEAD_CYCLES(DEAD)) dut (
    .clock_100Mhz          (clk),
    .reset                 (rst),
    .LED_activating_counter(sel),
    .display_value         (display_value),
    .dp_mask               (dp_mask),
    .value_valid           (value_valid),
    .blank_lz              (blank_lz),
    .value_ack             (value_ack),
    .frame_done            (frame_done),
    .Anode_Activate        (Anode_Activate),
    .LED_out               (LED_out),
    .dp_out                (dp_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] model_img(input logic [1:0] s);
    logic [15:0] upper;
    upper = m_shadow >> (12 - 4 * int'(s));
    if (blank_lz && s != 2'd3 && upper == 16'd0) return 12'hFFF;
    return {~(4'b1000 >> s), seg_tab[upper[3:0]], ~m_sdp[3 - int'(s)]};
  endfunction

  task automatic model_reset();
    m_shadow = 16'd0; m_pend = 16'd0; m_sdp = 4'd0; m_pdp = 4'd0;
    m_flag = 1'b0; cur_sel = 2'd0;
  endtask

  // Drives one select (plus optional write) and queues the expected per-cycle outputs.
  task automatic apply_step(input step_t st);
    bit wrap;
    wrap = (cur_sel == 2'd3) && (st.s == 2'd0);
    if (wrap && m_flag) begin
      m_shadow = m_pend; m_sdp = m_pdp; m_flag = 1'b0;
    end
    if (st.s != cur_sel) begin
      for (int i = 0; i < DEAD; i++) begin
        exp_img_q.push_back(12'hFFF);
        exp_fr_q.push_back(i == 0 && wrap);
        exp_ack_q.push_back(i == 0 && st.wr);
      end
    end
    exp_img_q.push_back(model_img(st.s));
    exp_fr_q.push_back((st.s != cur_sel && DEAD == 0) ? wrap : 1'b0);
    exp_ack_q.push_back((st.s == cur_sel || DEAD == 0) ? st.wr : 1'b0);
    sel = st.s;
    value_valid = st.wr;
    display_value = st.v;
    dp_mask = st.d;
    if (st.wr) begin
      m_pend = st.v; m_pdp = st.d; m_flag = 1'b1;
    end
    cur_sel = st.s;
  endtask

  task automatic test_reset();
    step_t st;
    rst = 1'b1; sel = 2'd0; value_valid = 1'b0; blank_lz = 1'b0;
    display_value = 16'd0; dp_mask = 4'd0;
    model_reset();
    tick(); tick();
    checks++;
    if (Anode_Activate !== 4'b1111 || LED_out !== 7'b1111111 || dp_out !== 1'b1 ||
        value_ack !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got an=%b led=%b dp=%b ack=%b fr=%b, want an=1111 led=1111111 dp=1 ack=0 fr=0",
               Anode_Activate, LED_out, dp_out, value_ack, frame_done);
    end
    rst = 1'b0;
    st = '{2'd0, 1'b0, 16'd0, 4'd0};
    apply_step(st);
    while (exp_img_q.size() != 0) begin
      logic [11:0] e; logic f, a;
      tick(); value_valid = 1'b0;
      e = exp_img_q.pop_front(); f = exp_fr_q.pop_front(); a = exp_ack_q.pop_front();
      checks++;
      if ({Anode_Activate, LED_out, dp_out} !== e || frame_done !== f || value_ack !== a) begin
        errors++;
        $display("FAIL first_digit: got an=%b led=%b dp=%b fr=%b ack=%b, want an=%b led=%b dp=%b fr=%b ack=%b",
                 Anode_Activate, LED_out, dp_out, frame_done, value_ack, e[11:8], e[7:1], e[0], f, a);
      end
    end
  endtask

  task automatic test_capture_frame_dead();
    step_t steps[$] = '{
      '{2'd0, 1'b1, 16'h12AF, 4'b0010}, '{2'd1, 1'b0, 16'd0, 4'd0},
      '{2'd2, 1'b0, 16'd0, 4'd0}, '{2'd3, 1'b0, 16'd0, 4'd0},
      '{2'd0, 1'b0, 16'd0, 4'd0}, '{2'd1, 1'b0, 16'd0, 4'd0},
      '{2'd2, 1'b0, 16'd0, 4'd0}, '{2'd3, 1'b0, 16'd0, 4'd0}};
    for (int i = 0; i < steps.size(); i++) begin
      apply_step(steps[i]);
      while (exp_img_q.size() != 0) begin
        logic [11:0] e; logic f, a;
        tick(); value_valid = 1'b0;
        e = exp_img_q.pop_front(); f = exp_fr_q.pop_front(); a = exp_ack_q.pop_front();
        checks++;
        if ({Anode_Activate, LED_out, dp_out} !== e || frame_done !== f || value_ack !== a) begin
          errors++;
          $display("FAIL capture_frame step %0d: got an=%b led=%b dp=%b fr=%b ack=%b, want an=%b led=%b dp=%b fr=%b ack=%b",
                   i, Anode_Activate, LED_out, dp_out, frame_done, value_ack, e[11:8], e[7:1], e[0], f, a);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t steps[$] = '{
      '{2'd3, 1'b1, 16'h0000, 4'd0}, '{2'd3, 1'b1, 16'h0305, 4'd0},
      '{2'd0, 1'b0, 16'd0, 4'd0}, '{2'd1, 1'b0, 16'd0, 4'd0},
      '{2'd2, 1'b0, 16'd0, 4'd0}, '{2'd3, 1'b0, 16'd0, 4'd0},
      '{2'd0, 1'b1, 16'h0007, 4'd0}, '{2'd1, 1'b0, 16'd0, 4'd0},
      '{2'd2, 1'b0, 16'd0, 4'd0}, '{2'd3, 1'b0, 16'd0, 4'd0},
      '{2'd0, 1'b0, 16'd0, 4'd0}, '{2'd1, 1'b0, 16'd0, 4'd0},
      '{2'd2, 1'b0, 16'd0, 4'd0}, '{2'd3, 1'b0, 16'd0, 4'd0}};
    for (int i = 0; i < steps.size(); i++) begin
      apply_step(steps[i]);
      while (exp_img_q.size() != 0) begin
        logic [11:0] e; logic f, a;
        tick(); value_valid = 1'b0;
        e = exp_img_q.pop_front(); f = exp_fr_q.pop_front(); a = exp_ack_q.pop_front();
        checks++;
        if ({Anode_Activate, LED_out, dp_out} !== e || frame_done !== f || value_ack !== a) begin
          errors++;
          $display("FAIL back_to_back step %0d: got an=%b led=%b dp=%b fr=%b ack=%b, want an=%b led=%b dp=%b fr=%b ack=%b",
                   i, Anode_Activate, LED_out, dp_out, frame_done, value_ack, e[11:8], e[7:1], e[0], f, a);
        end
      end
    end
  endtask

  task automatic test_blank_lz();
    step_t steps[$] = '{
      '{2'd3, 1'b1, 16'h0040, 4'b1111}, '{2'd0, 1'b0, 16'd0, 4'd0},
      '{2'd1, 1'b0, 16'd0, 4'd0}, '{2'd2, 1'b0, 16'd0, 4'd0},
      '{2'd3, 1'b0, 16'd0, 4'd0}, '{2'd3, 1'b1, 16'h0000, 4'd0},
      '{2'd1, 1'b0, 16'd0, 4'd0}, '{2'd2, 1'b0, 16'd0, 4'd0},
      '{2'd0, 1'b0, 16'd0, 4'd0}, '{2'd2, 1'b0, 16'd0, 4'd0},
      '{2'd3, 1'b0, 16'd0, 4'd0}, '{2'd0, 1'b0, 16'd0, 4'd0},
      '{2'd1, 1'b0, 16'd0, 4'd0}, '{2'd2, 1'b0, 16'd0, 4'd0},
      '{2'd3, 1'b0, 16'd0, 4'd0}};
    blank_lz = 1'b1;
    for (int i = 0; i < steps.size(); i++) begin
      apply_step(steps[i]);
      while (exp_img_q.size() != 0) begin
        logic [11:0] e; logic f, a;
        tick(); value_valid = 1'b0;
        e = exp_img_q.pop_front(); f = exp_fr_q.pop_front(); a = exp_ack_q.pop_front();
        checks++;
        if ({Anode_Activate, LED_out, dp_out} !== e || frame_done !== f || value_ack !== a) begin
          errors++;
          $display("FAIL blank_lz step %0d: got an=%b led=%b dp=%b fr=%b ack=%b, want an=%b led=%b dp=%b fr=%b ack=%b",
                   i, Anode_Activate, LED_out, dp_out, frame_done, value_ack, e[11:8], e[7:1], e[0], f, a);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_reset_mid_dead();
    step_t steps[$] = '{
      '{2'd0, 1'b0, 16'd0, 4'd0}, '{2'd1, 1'b0, 16'd0, 4'd0},
      '{2'd2, 1'b0, 16'd0, 4'd0}, '{2'd3, 1'b0, 16'd0, 4'd0},
      '{2'd0, 1'b0, 16'd0, 4'd0}, '{2'd1, 1'b0, 16'd0, 4'd0},
      '{2'd2, 1'b0, 16'd0, 4'd0}, '{2'd3, 1'b0, 16'd0, 4'd0}};
    sel = 2'd1; value_valid = 1'b1; display_value = 16'hBEEF; dp_mask = 4'hF;
    tick();
    value_valid = 1'b0;
    rst = 1'b1;
    #2;
    checks++;
    if (Anode_Activate !== 4'b1111 || LED_out !== 7'b1111111 || dp_out !== 1'b1 ||
        value_ack !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_dead: got an=%b led=%b dp=%b ack=%b fr=%b, want an=1111 led=1111111 dp=1 ack=0 fr=0",
               Anode_Activate, LED_out, dp_out, value_ack, frame_done);
    end
    sel = 2'd0;
    tick(); tick();
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < steps.size(); i++) begin
      apply_step(steps[i]);
      while (exp_img_q.size() != 0) begin
        logic [11:0] e; logic f, a;
        tick(); value_valid = 1'b0;
        e = exp_img_q.pop_front(); f = exp_fr_q.pop_front(); a = exp_ack_q.pop_front();
        checks++;
        if ({Anode_Activate, LED_out, dp_out} !== e || frame_done !== f || value_ack !== a) begin
          errors++;
          $display("FAIL after_reset step %0d: got an=%b led=%b dp=%b fr=%b ack=%b, want an=%b led=%b dp=%b fr=%b ack=%b",
                   i, Anode_Activate, LED_out, dp_out, frame_done, value_ack, e[11:8], e[7:1], e[0], f, a);
        end
      end
    end
  endtask

  initial begin
    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
    seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
    seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
    seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
    seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;
    test_reset();
    test_capture_frame_dead();
    test_back_to_back();
    test_blank_lz();
    test_reset_mid_dead();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Consumes the 2-bit digit-select produced by the refresh counter and drives the four-digit, common-anode seven-segment display: anode enables, segment cathodes and decimal point. It double-buffers the value to display so updates land only on frame boundaries, which prevents torn readings. It inserts a blanking dead time at every digit switch to suppress ghosting, and it optionally blanks leading zeros. It sits between the frequency-measurement datapath, which writes values, and the board pins.

## Interface
- DEAD_CYCLES, 1024, clock cycles all anodes are held off after each select change; range 0..65535; 0 disables dead time.
- clock_100Mhz  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- LED_activating_counter  input  2  digit select from the refresh counter; 0 = leftmost digit, 3 = rightmost digit.
- display_value  input  16  four hex nibbles; [15:12] is the leftmost digit, [3:0] the rightmost.
- dp_mask  input  4  decimal-point enables captured with the value; bit 3 = leftmost digit; 1 = lit.
- value_valid  input  1  single-cycle write strobe for display_value and dp_mask.
- blank_lz  input  1  level input; 1 enables leading-zero blanking.
- value_ack  output  1  one-cycle pulse confirming a capture.
- frame_done  output  1  one-cycle pulse at each 3→0 select wrap.
- Anode_Activate  output  4  active-low anode enables; bit 3 = leftmost digit.
- LED_out  output  7  active-low segments, ordered {a,b,c,d,e,f,g}.
- dp_out  output  1  active-low decimal point.

## Operation
- Registers:
  - pending: 16-bit value + 4-bit dp, with pending_flag.
  - shadow: 16-bit value + 4-bit dp; drives the display.
  - sel_prev: 2 bits.
  - dead_cnt: 16 bits.
- Capture: when value_valid=1, pending ← {display_value, dp_mask} and pending_flag ← 1. value_ack=1 on the next cycle. If a new capture arrives while pending_flag is already set, the new value overwrites pending (last write wins).
- Frame boundary: sel_prev==3 && LED_activating_counter==0.
  - frame_done pulses on every boundary.
  - If pending_flag is set, shadow ← pending and pending_flag ← 0.
  - No other select transition counts as a boundary (e.g. 2→0, or 3→1).
- Simultaneous boundary and value_valid:
  - shadow takes the pre-existing pending contents, if pending_flag was set.
  - pending takes the new value.
  - pending_flag ends at 1.
- Select change: LED_activating_counter != sel_prev loads dead_cnt ← DEAD_CYCLES. A change that occurs while dead_cnt is nonzero reloads it.
- sel_prev ← LED_activating_counter every cycle.
- Digit output:
  - While dead_cnt != 0, outputs are all off: Anode_Activate=4'b1111, LED_out=7'b1111111, dp_out=1. dead_cnt decrements each cycle.
  - Otherwise, sel s drives one anode low: s=0 → 4'b0111, s=1 → 4'b1011, s=2 → 4'b1101, s=3 → 4'b1110. LED_out is the decoded nibble of shadow for that digit, and dp_out = ~shadow_dp[that digit].
- Hex decode, LED_out values:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Leading-zero blanking, active when blank_lz=1:
  - A digit is blanked when it and every digit to its left are nibble 0.
  - A blanked digit shows Anode_Activate=4'b1111, LED_out all 1 and dp_out=1, even if its dp bit is set.
  - The rightmost digit (s=3) is never blanked. Value 0x0000 therefore shows a single "0".

## Timing
- All outputs are registered.
- Reset values:
  - Anode_Activate=4'b1111, LED_out=7'b1111111, dp_out=1, value_ack=0, frame_done=0.
  - shadow=0, pending=0, pending_flag=0, sel_prev=0, dead_cnt=0.
- Reset asserted mid-operation clears all state immediately; any pending value is discarded.
- value_valid sampled at edge t → value_ack high for the cycle after edge t. The new value reaches the display only after the next boundary.
- Boundary seen at edge t → frame_done high in cycle t+1. The shadow update is effective at edge t; the new digit-0 image appears after dead time.
- Select change sampled at edge t → outputs all off from t+1 through t+DEAD_CYCLES; new digit driven at t+DEAD_CYCLES+1.
- With DEAD_CYCLES=0, the new digit is driven at t+1.
- Steady select with dead_cnt=0 → outputs track a shadow change with 1-cycle latency.

## Test plan
- Reset, hold select=0, DEAD_CYCLES=4, shadow=0, blank_lz=0 → first cycle after release: Anode_Activate=0111, LED_out=0000001, dp_out=1.
- value_valid with 0x12AF and dp_mask=0010, then cycle select 0→1→2→3→0 → value_ack one cycle after the strobe; frame_done on the wrap. The next frame shows 1, 2, A, F (LED_out 1001111, 0010010, 0001000, 0111000) with the dp lit only on the A digit.
- DEAD_CYCLES=4, select 1→2 at edge t → outputs 1111 / 1111111 for cycles t+1..t+4; Anode_Activate=1101 at t+5.
- Write 0x0000 then 0x0305 in consecutive cycles before a wrap → after the wrap, shadow=0x0305. Write 0x0007 on the exact wrap cycle → shadow stays 0x0305, and 0x0007 is applied at the following wrap.
- blank_lz=1, shadow=0x0040 → digits 0 and 1 dark (anodes stay 1111); digit 2 shows 4 (1001100); digit 3 shows 0. With shadow=0x0000, only digit 3 is lit.
- Assert reset mid-dead-time with pending_flag set → outputs return to all-off immediately. After release and a wrap, shadow=0 and frame_done still pulses.
